// File: rtl/booth_mult_seq.sv
// Sequential radix-4 (modified Booth) multiplier with valid/ready handshakes.
// One Booth digit is retired per clock, and a product appears ITER edges
// after its operands are accepted.
// Ports:
//   clk, rst      - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready, A, B, signed_mode - operand handshake and payload
//   out_valid/out_ready, P               - product handshake and payload
//   busy          - high while digits are being retired (CALC)
module booth_mult_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               busy
);

  localparam int unsigned ITER  = WIDTH / 2 + 1;
  localparam int unsigned ACC_W = 2 * WIDTH + 4;
  localparam int unsigned MPL_W = WIDTH + 2;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  // Reject unsupported widths at elaboration.
  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("booth_mult_seq: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [ACC_W-1:0]     mcand_q, mcand_d;
  logic [MPL_W-1:0]     mplr_q, mplr_d;
  logic                 bprev_q, bprev_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;

  logic [2:0]           triplet;
  logic [ACC_W-1:0]     pp;
  logic [ACC_W-1:0]     acc_sum;
  logic                 ext_a;
  logic                 ext_b;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign P         = p_q;

  // Booth digit recoding. mcand_q is pre-shifted by 2i, so the selected
  // partial product already carries its 4^i weight; arithmetic is modulo
  // 2^ACC_W, which leaves the low 2*WIDTH bits exact.
  always_comb begin
    triplet = {mplr_q[1:0], bprev_q};
    pp      = '0;
    unique case (triplet)
      3'b001, 3'b010: pp = mcand_q;
      3'b011:         pp = mcand_q << 1;
      3'b100:         pp = -(mcand_q << 1);
      3'b101, 3'b110: pp = -mcand_q;
      default:        pp = '0;
    endcase
    acc_sum = acc_q + pp;
  end

  // Extension bits: sign bit in signed mode, zero otherwise.
  assign ext_a = signed_mode & A[WIDTH-1];
  assign ext_b = signed_mode & B[WIDTH-1];

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplr_d      = mplr_q;
    bprev_d     = bprev_q;
    p_d         = p_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d    = {{(ACC_W - WIDTH){ext_a}}, A};
          mplr_d     = {{2{ext_b}}, B};
          bprev_d    = 1'b0;
          acc_d      = '0;
          cnt_d      = '0;
          state_d    = S_CALC;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      S_CALC: begin
        acc_d   = acc_sum;
        mcand_d = mcand_q << 2;
        mplr_d  = mplr_q >> 2;
        bprev_d = mplr_q[1];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d     = S_DONE;
          p_d         = acc_sum[2*WIDTH-1:0];
          busy_d      = 1'b0;
          out_valid_d = 1'b1;
        end
      end

      S_DONE: begin
        // Input is not offered in the hand-off edge; IDLE accepts next edge.
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      bprev_q     <= 1'b0;
      p_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplr_q      <= mplr_d;
      bprev_q     <= bprev_d;
      p_q         <= p_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule
